// File: rtl/ahb_master_arbiter.sv
// AHB-lite arbiter/multiplexer: shares one slave port among NUM_MST masters with round-robin
// grants that never split a fixed-length burst; address and data phase owners tracked separately.
module ahb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_MST    = 2
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic [NUM_MST-1:0]            m_hbusreq,
  output logic [NUM_MST-1:0]            m_hgrant,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_MST*2-1:0]          m_htrans,
  input  logic [NUM_MST-1:0]            m_hwrite,
  input  logic [NUM_MST*3-1:0]          m_hsize,
  input  logic [NUM_MST*3-1:0]          m_hburst,
  input  logic [NUM_MST*4-1:0]          m_hprot,
  input  logic [NUM_MST*DATA_WIDTH-1:0] m_hwdata,
  output logic [ADDR_WIDTH-1:0]         haddr,
  output logic [1:0]                    htrans,
  output logic                          hwrite,
  output logic [2:0]                    hsize,
  output logic [2:0]                    hburst,
  output logic [3:0]                    hprot,
  output logic [DATA_WIDTH-1:0]         hwdata,
  output logic                          hsel,
  input  logic                          hreadyout,
  input  logic                          hresp,
  input  logic [DATA_WIDTH-1:0]         hrdata,
  output logic                          hready,
  output logic [1:0]                    addr_owner,
  output logic [1:0]                    data_owner
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [2:0] BurstSingle = 3'b000;

  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [1:0]         grant_idx_q;
  logic [1:0]         addr_owner_q, data_owner_q;
  logic [3:0]         beat_q, beat_d;
  logic               hsel_q;

  // Master buses padded to four entries so the 2-bit owner indices select without width games.
  logic [ADDR_WIDTH-1:0] addr_arr  [4];
  logic [DATA_WIDTH-1:0] wdata_arr [4];
  logic [1:0]            trans_arr [4];
  logic [2:0]            size_arr  [4];
  logic [2:0]            burst_arr [4];
  logic [3:0]            prot_arr  [4];
  logic                  write_arr [4];
  logic [3:0]            req_pad;

  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NUM_MST) begin : g_used
      assign addr_arr[g]  = m_haddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[g] = m_hwdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign trans_arr[g] = m_htrans[g*2 +: 2];
      assign size_arr[g]  = m_hsize[g*3 +: 3];
      assign burst_arr[g] = m_hburst[g*3 +: 3];
      assign prot_arr[g]  = m_hprot[g*4 +: 4];
      assign write_arr[g] = m_hwrite[g];
      assign req_pad[g]   = m_hbusreq[g];
    end else begin : g_tie
      assign addr_arr[g]  = '0;
      assign wdata_arr[g] = '0;
      assign trans_arr[g] = '0;
      assign size_arr[g]  = '0;
      assign burst_arr[g] = '0;
      assign prot_arr[g]  = '0;
      assign write_arr[g] = 1'b0;
      assign req_pad[g]   = 1'b0;
    end
  end

  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic       own_req;

  assign own_trans = trans_arr[addr_owner_q];
  assign own_burst = burst_arr[addr_owner_q];
  assign own_req   = req_pad[addr_owner_q];

  // Beat counter holds the number of beats still to come after the one being accepted.
  always_comb begin
    beat_d = beat_q;
    if (!hreadyout) begin
      if (hresp) beat_d = '0;
    end else begin
      case (own_trans)
        TransNonseq: begin
          case (own_burst)
            3'b010, 3'b011: beat_d = 4'd3;
            3'b100, 3'b101: beat_d = 4'd7;
            3'b110, 3'b111: beat_d = 4'd15;
            default:        beat_d = 4'd0;
          endcase
        end
        TransSeq: beat_d = (beat_q == 4'd0) ? 4'd0 : beat_q - 4'd1;
        default:  beat_d = beat_q;
      endcase
    end
  end

  logic last_beat, handover;

  assign last_beat = (own_trans == TransNonseq && own_burst == BurstSingle) ||
                     (own_trans == TransSeq && beat_q == 4'd1);
  assign handover  = hreadyout && (beat_d == 4'd0) &&
                     (own_trans == TransIdle || last_beat || !own_req || hresp);

  // Round-robin search from addr_owner+1; the owner itself is tried last.
  logic [2:0] cand;
  logic [1:0] win_idx;
  logic       win_found;
  logic [3:0] win_onehot;

  always_comb begin
    win_idx   = addr_owner_q;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_MST; k++) begin
      cand = {1'b0, addr_owner_q} + 3'(k);
      if (cand >= 3'(NUM_MST)) cand = cand - 3'(NUM_MST);
      if (!win_found && req_pad[cand[1:0]]) begin
        win_idx   = cand[1:0];
        win_found = 1'b1;
      end
    end
  end

  assign win_onehot = 4'b0001 << win_idx;
  assign grant_d    = win_onehot[NUM_MST-1:0];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      grant_q      <= NUM_MST'(1);
      grant_idx_q  <= '0;
      addr_owner_q <= '0;
      data_owner_q <= '0;
      beat_q       <= '0;
      hsel_q       <= 1'b0;
    end else begin
      hsel_q <= 1'b1;
      beat_q <= beat_d;
      if (hreadyout) begin
        addr_owner_q <= grant_idx_q;
        data_owner_q <= addr_owner_q;
        if (handover) begin
          grant_q     <= grant_d;
          grant_idx_q <= win_idx;
        end
      end
    end
  end

  assign m_hgrant   = grant_q;
  assign addr_owner = addr_owner_q;
  assign data_owner = data_owner_q;
  assign hsel       = hsel_q;
  assign hready     = hreadyout;

  assign haddr  = addr_arr[addr_owner_q];
  assign htrans = hresetn ? own_trans : TransIdle;
  assign hwrite = write_arr[addr_owner_q];
  assign hsize  = size_arr[addr_owner_q];
  assign hburst = own_burst;
  assign hprot  = prot_arr[addr_owner_q];
  assign hwdata = wdata_arr[data_owner_q];

  // Read data and response go straight from the slave to every master.
  logic unused_rdata;
  assign unused_rdata = ^hrdata;

endmodule
